// File: rtl/l2_tlb_repl_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_tlb_repl_ctrl_pkg
// Brief    : Shared types and constants for the L2 TLB replacement controller.
// Revision : 1.0 - initial release
// ============================================================================
package l2_tlb_repl_ctrl_pkg;

    localparam int WAYS = 4;

    // Bit positions inside the 4-bit pseudo-LRU tree vector.
    localparam int PLRU_ROOT  = 1;
    localparam int PLRU_LEFT  = 2;
    localparam int PLRU_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } state_t;

    function automatic logic [1:0] way_idx(input logic [WAYS-1:0] oh);
        way_idx = 2'd0;
        for (int i = 0; i < WAYS; i++) begin
            if (oh[i]) way_idx = 2'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_tlb_repl_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_tlb_repl_ctrl_if
// Brief    : Lookup, miss, page-walk and fill signals of the replacement controller.
// Revision : 1.0 - initial release
// ============================================================================
interface l2_tlb_repl_ctrl_if #(
    parameter int VPN_W = 27
);
    logic             hit_valid;
    logic [3:0]       hit_way;
    logic             miss_valid;
    logic [VPN_W-1:0] miss_vpn;
    logic             miss_ready;
    logic             ptw_req_valid;
    logic             ptw_req_ready;
    logic [VPN_W-1:0] ptw_req_vpn;
    logic             ptw_resp_valid;
    logic             ptw_resp_err;
    logic             fill_valid;
    logic [1:0]       fill_way;
    logic             flush;
    logic             busy;
    logic [3:0]       plru_state;
    logic [3:0]       valid_vec;

    modport master (
        output hit_valid, hit_way, miss_valid, miss_vpn, ptw_req_ready,
               ptw_resp_valid, ptw_resp_err, flush,
        input  miss_ready, ptw_req_valid, ptw_req_vpn, fill_valid, fill_way,
               busy, plru_state, valid_vec
    );

    modport slave (
        input  hit_valid, hit_way, miss_valid, miss_vpn, ptw_req_ready,
               ptw_resp_valid, ptw_resp_err, flush,
        output miss_ready, ptw_req_valid, ptw_req_vpn, fill_valid, fill_way,
               busy, plru_state, valid_vec
    );
endinterface
`default_nettype wire

// File: rtl/l2_tlb_plru_tree.sv
`default_nettype none
// ============================================================================
// Module   : l2_tlb_plru_tree
// Brief    : Combinational 4-way tree pseudo-LRU touch and victim selection.
// Revision : 1.0 - initial release
// ============================================================================
module l2_tlb_plru_tree
    import l2_tlb_repl_ctrl_pkg::*;
(
    input  wire logic [3:0] state,
    input  wire logic [1:0] way,
    input  wire logic       touch_en,
    input  wire logic [3:0] valid_vec,
    output logic      [3:0] next_state,
    output logic      [1:0] victim
);

    always_comb begin
        next_state    = state;
        next_state[0] = 1'b0;
        if (touch_en) begin
            // Point every node on the touched path away from the touched way.
            next_state[PLRU_ROOT] = ~way[1];
            if (way[1]) next_state[PLRU_RIGHT] = ~way[0];
            else        next_state[PLRU_LEFT]  = ~way[0];
        end
    end

    always_comb begin
        victim = {state[PLRU_ROOT],
                  state[PLRU_ROOT] ? state[PLRU_RIGHT] : state[PLRU_LEFT]};
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) victim = 2'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_tlb_repl_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : l2_tlb_repl_ctrl
// Brief    : L2 TLB miss handler: page-walk FSM, pseudo-LRU victim and fill.
//            Optional hit/miss counters enabled by macro L2_TLB_REPL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module l2_tlb_repl_ctrl
    import l2_tlb_repl_ctrl_pkg::*;
#(
    parameter int VPN_W  = 27,
    parameter int PERF_W = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    l2_tlb_repl_ctrl_if.slave   bus
`ifdef L2_TLB_REPL_PERF_EN
    ,
    output logic [PERF_W-1:0]   hit_cnt,
    output logic [PERF_W-1:0]   miss_cnt
`endif
);

    state_t           r_state;
    state_t           w_next;
    logic [VPN_W-1:0] r_vpn;
    logic [1:0]       r_victim;
    logic [3:0]       r_plru;
    logic [3:0]       r_valid;

    logic             w_hit_touch;
    logic [1:0]       w_hit_way;
    logic             w_fill;
    logic             w_miss_acc;
    logic [3:0]       w_plru_hit;
    logic [3:0]       w_plru_next;
    logic [1:0]       w_victim_pre;
    logic [1:0]       w_victim_post;
    logic [1:0]       w_victim;

    assign w_hit_touch = bus.hit_valid && $onehot(bus.hit_way) && !bus.flush;
    assign w_hit_way   = way_idx(bus.hit_way);
    assign w_fill      = (r_state == ST_FILL) && !bus.flush;
    assign w_miss_acc  = (r_state == ST_IDLE) && bus.miss_valid && !bus.flush;

    // Hit touch first, fill touch on top of it, so a filled way ends up MRU.
    l2_tlb_plru_tree u_hit_touch (
        .state      (r_plru),
        .way        (w_hit_way),
        .touch_en   (w_hit_touch),
        .valid_vec  (r_valid),
        .next_state (w_plru_hit),
        .victim     (w_victim_pre)
    );

    l2_tlb_plru_tree u_fill_touch (
        .state      (w_plru_hit),
        .way        (r_victim),
        .touch_en   (w_fill),
        .valid_vec  (r_valid),
        .next_state (w_plru_next),
        .victim     (w_victim_post)
    );

    // Victim latched on FILL entry reflects a hit landing on that same edge.
    assign w_victim = w_hit_touch ? w_victim_post : w_victim_pre;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.miss_valid)     w_next = ST_REQ;
            ST_REQ:  if (bus.ptw_req_ready)  w_next = ST_WAIT;
            ST_WAIT: if (bus.ptw_resp_valid) w_next = bus.ptw_resp_err ? ST_IDLE : ST_FILL;
            ST_FILL:                         w_next = ST_IDLE;
            default:                         w_next = ST_IDLE;
        endcase
        if (bus.flush) w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_vpn    <= '0;
            r_victim <= 2'd0;
            r_plru   <= 4'h0;
            r_valid  <= 4'h0;
        end else begin
            r_state <= w_next;
            r_plru  <= w_plru_next;
            if (w_miss_acc) r_vpn <= bus.miss_vpn;
            if ((r_state == ST_WAIT) && (w_next == ST_FILL)) r_victim <= w_victim;
            if (bus.flush)   r_valid <= 4'h0;
            else if (w_fill) r_valid[r_victim] <= 1'b1;
        end
    end

    assign bus.miss_ready    = (r_state == ST_IDLE) && !bus.flush;
    assign bus.ptw_req_valid = (r_state == ST_REQ);
    assign bus.ptw_req_vpn   = r_vpn;
    assign bus.fill_valid    = w_fill;
    assign bus.fill_way      = r_victim;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.plru_state    = r_plru;
    assign bus.valid_vec     = r_valid;

`ifdef L2_TLB_REPL_PERF_EN
    logic [PERF_W-1:0] r_hit_cnt;
    logic [PERF_W-1:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_touch && !(&r_hit_cnt))  r_hit_cnt  <= r_hit_cnt + PERF_W'(1);
            if (w_miss_acc  && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + PERF_W'(1);
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire
